// File: rtl/onfi_pkg.sv
// onfi_pkg: shared FSM state, byte-type and opcode definitions for the ONFI command/address path
package onfi_pkg;
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WE_LOW, S_WE_HIGH, S_WAIT_WB, S_WAIT_RB, S_DONE} state_t;
   typedef enum logic {BT_CMD, BT_ADDR} btype_t;
   localparam logic [7:0] OP_RESET       = 8'hFF;
   localparam logic [7:0] OP_READ1       = 8'h00;
   localparam logic [7:0] OP_READ2       = 8'h30;
   localparam logic [7:0] OP_READ_STATUS = 8'h70;
   localparam logic [7:0] OP_READ_ID     = 8'h90;
   localparam logic [7:0] OP_PROG1       = 8'h80;
   localparam logic [7:0] OP_PROG2       = 8'h10;
   localparam logic [7:0] OP_ERASE1      = 8'h60;
   localparam logic [7:0] OP_ERASE2      = 8'hD0;
   localparam logic [2:0] MAX_NADDR      = 3'd5;
   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a > b ? a : b;
      m = m > c ? m : c;
      return m > d ? m : d;
   endfunction
endpackage

// File: rtl/onfi_sync2.sv
// onfi_sync2: two-flop synchroniser for a single asynchronous input
// Ports: clk/rst_n (async active-low), d async input, q synchronised output (RST_VAL while in reset)
module onfi_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic m;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {q, m} <= {RST_VAL, RST_VAL};
      else {q, m} <= {m, d};
endmodule

// File: rtl/onfi_cmd_addr_gen.sv
// onfi_cmd_addr_gen: issues one ONFI command/address latch sequence per request with cycle-counted WE_n timing
// Ports: sysclk/rst_n (async active-low); req_* request handshake and fields; done/err_timeout completion;
//        busy; nand_* registered NAND bus outputs; nand_rb_n asynchronous ready/busy input
module onfi_cmd_addr_gen
   import onfi_pkg::*;
#(
   parameter int T_SETUP    = 2,
   parameter int T_WP       = 3,
   parameter int T_WH       = 2,
   parameter int T_WB       = 17,
   parameter int RB_TIMEOUT = 65535
) (
   input  logic        sysclk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_cmd,
   input  logic [39:0] req_addr,
   input  logic [2:0]  req_naddr,
   input  logic        req_cmd2_en,
   input  logic [7:0]  req_cmd2,
   input  logic        req_wait_rb,
   output logic        done,
   output logic        err_timeout,
   output logic        busy,
   output logic        nand_ce_n,
   output logic        nand_cle,
   output logic        nand_ale,
   output logic        nand_we_n,
   output logic        nand_re_n,
   output logic [7:0]  nand_dq_o,
   output logic        nand_dq_oe,
   input  logic        nand_rb_n
);
   localparam int PW = $clog2(max4(T_SETUP, T_WP, T_WH, T_WB) + 1);
   localparam int TW = $clog2(RB_TIMEOUT + 1);
   state_t        state;
   btype_t        nt;
   logic [PW-1:0] cnt;
   logic [TW-1:0] tcnt;
   logic [2:0]    idx, nidx, naddr_q, naddr_c, last_q;
   logic [39:0]   addr_q;
   logic [7:0]    cmd2_q, nb;
   logic          wait_q, rb_s, pend, has_next;
   int            lim;
   onfi_sync2 #(.RST_VAL(1'b1)) u_rb_sync (.clk(sysclk), .rst_n(rst_n), .d(nand_rb_n), .q(rb_s));
   assign req_ready = state == S_IDLE;
   assign busy      = !req_ready;
   assign nand_re_n = 1'b1;
   // byte idx+1 is address byte idx when it falls inside the address run, otherwise it is cmd2
   always_comb begin
      naddr_c  = req_naddr > MAX_NADDR ? MAX_NADDR : req_naddr;
      nidx     = idx + 3'd1;
      nt       = nidx <= naddr_q ? BT_ADDR : BT_CMD;
      nb       = nt == BT_ADDR ? 8'(addr_q >> {idx, 3'd0}) : cmd2_q;
      has_next = idx < last_q;
      lim      = state == S_SETUP ? T_SETUP : state == S_WE_LOW ? T_WP : state == S_WE_HIGH ? T_WH : T_WB;
      pend     = cnt == PW'(lim - 1);
   end
   always_ff @(posedge sysclk or negedge rst_n)
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         tcnt        <= '0;
         idx         <= '0;
         naddr_q     <= '0;
         last_q      <= '0;
         addr_q      <= '0;
         cmd2_q      <= '0;
         wait_q      <= 1'b0;
         done        <= 1'b0;
         err_timeout <= 1'b0;
         nand_ce_n   <= 1'b1;
         nand_cle    <= 1'b0;
         nand_ale    <= 1'b0;
         nand_we_n   <= 1'b1;
         nand_dq_o   <= '0;
         nand_dq_oe  <= 1'b0;
      end else begin
         cnt         <= pend ? '0 : cnt + 1'b1;
         done        <= 1'b0;
         err_timeout <= 1'b0;
         case (state)
            S_IDLE: if (req_valid) begin
               state      <= S_SETUP;
               cnt        <= '0;
               idx        <= '0;
               naddr_q    <= naddr_c;
               last_q     <= naddr_c + {2'b00, req_cmd2_en};
               addr_q     <= req_addr;
               cmd2_q     <= req_cmd2;
               wait_q     <= req_wait_rb;
               nand_ce_n  <= 1'b0;
               nand_cle   <= 1'b1;
               nand_ale   <= 1'b0;
               nand_dq_o  <= req_cmd;
               nand_dq_oe <= 1'b1;
            end
            S_SETUP: if (pend) begin
               state     <= S_WE_LOW;
               nand_we_n <= 1'b0;
            end
            S_WE_LOW: if (pend) begin
               state     <= S_WE_HIGH;
               nand_we_n <= 1'b1;
            end
            S_WE_HIGH: if (pend) begin
               if (has_next) begin
                  state     <= S_SETUP;
                  idx       <= nidx;
                  nand_dq_o <= nb;
                  nand_cle  <= nt == BT_CMD;
                  nand_ale  <= nt == BT_ADDR;
               end else begin
                  state      <= wait_q ? S_WAIT_WB : S_DONE;
                  done       <= !wait_q;
                  nand_ce_n  <= !wait_q;
                  nand_cle   <= 1'b0;
                  nand_ale   <= 1'b0;
                  nand_dq_oe <= 1'b0;
               end
            end
            S_WAIT_WB: if (pend) begin
               state <= S_WAIT_RB;
               tcnt  <= '0;
            end
            S_WAIT_RB: begin
               tcnt <= tcnt + 1'b1;
               if (rb_s || tcnt == TW'(RB_TIMEOUT - 1)) begin
                  state       <= S_DONE;
                  done        <= 1'b1;
                  err_timeout <= !rb_s;
                  nand_ce_n   <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_onfi_cmd_addr_gen.sv
// tb_onfi_cmd_addr_gen: directed self-checking bench for onfi_cmd_addr_gen
module tb_onfi_cmd_addr_gen;
   logic        sysclk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, req_cmd2_en = 1'b0, req_wait_rb = 1'b0, nand_rb_n = 1'b1;
   logic [7:0]  req_cmd = '0, req_cmd2 = '0;
   logic [39:0] req_addr = '0;
   logic [2:0]  req_naddr = '0;
   logic        req_ready, done, err_timeout, busy, ce_n, cle, ale, we_n, re_n, dq_oe;
   logic [7:0]  dq_o;
   logic        req_valid_t = 1'b0;
   logic        req_ready_t, done_t, err_t, busy_t, ce_n_t, cle_t, ale_t, we_n_t, re_n_t, dq_oe_t;
   logic [7:0]  dq_o_t;
   int          n_cmp = 0, n_err = 0, cyc = 0, nb = 0, low = 0;
   int          last_acc = -1, last_done = -1, last_acc_t = -1, last_done_t = -1;
   int          rb_total = 0, low_at = -1, high_at = -1;
   logic [9:0]  blog [32];
   int          blow [32], brise [32];
   logic [9:0]  cur = '0;
   logic        prev_we = 1'b1;
   logic [9:0]  exp_pr [7] = '{10'h200, 10'h100, 10'h101, 10'h102, 10'h103, 10'h104, 10'h230};
   always #3 sysclk = ~sysclk;
   onfi_cmd_addr_gen dut (
      .sysclk(sysclk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_addr(req_addr), .req_naddr(req_naddr), .req_cmd2_en(req_cmd2_en),
      .req_cmd2(req_cmd2), .req_wait_rb(req_wait_rb), .done(done), .err_timeout(err_timeout),
      .busy(busy), .nand_ce_n(ce_n), .nand_cle(cle), .nand_ale(ale), .nand_we_n(we_n),
      .nand_re_n(re_n), .nand_dq_o(dq_o), .nand_dq_oe(dq_oe), .nand_rb_n(nand_rb_n));
   onfi_cmd_addr_gen #(.RB_TIMEOUT(100)) dut_to (
      .sysclk(sysclk), .rst_n(rst_n), .req_valid(req_valid_t), .req_ready(req_ready_t),
      .req_cmd(req_cmd), .req_addr(req_addr), .req_naddr(req_naddr), .req_cmd2_en(req_cmd2_en),
      .req_cmd2(req_cmd2), .req_wait_rb(req_wait_rb), .done(done_t), .err_timeout(err_t),
      .busy(busy_t), .nand_ce_n(ce_n_t), .nand_cle(cle_t), .nand_ale(ale_t), .nand_we_n(we_n_t),
      .nand_re_n(re_n_t), .nand_dq_o(dq_o_t), .nand_dq_oe(dq_oe_t), .nand_rb_n(1'b0));
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // one clock: records accepts, done pulses, WE_n byte log and drives the R/B_n model
   task automatic tick();
      logic a, at;
      a  = req_valid && req_ready;
      at = req_valid_t && req_ready_t;
      @(posedge sysclk);
      #1;
      cyc++;
      if (a) last_acc = cyc - 1;
      if (at) last_acc_t = cyc - 1;
      if (done) last_done = cyc;
      if (done_t) last_done_t = cyc;
      if (prev_we && !we_n) begin
         cur = {cle, ale, dq_o};
         low = 1;
      end else if (!prev_we && !we_n) low++;
      else if (!prev_we && we_n && nb < 32) begin
         blog[nb] = cur;
         blow[nb] = low;
         brise[nb] = cyc;
         nb++;
         if (nb == rb_total) begin
            low_at  = cyc + 10;
            high_at = cyc + 210;
         end
      end
      prev_we = we_n;
      nand_rb_n = !(cyc >= low_at && cyc < high_at);
   endtask
   task automatic send(input logic [7:0] c, input logic [2:0] na, input logic [39:0] ad,
                       input logic c2e, input logic [7:0] c2, input logic wrb);
      int n;
      req_cmd = c; req_naddr = na; req_addr = ad; req_cmd2_en = c2e; req_cmd2 = c2; req_wait_rb = wrb;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin tick(); n++; end
      tick();
      req_valid = 1'b0;
   endtask
   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin tick(); n++; end
      check("done_seen", done, 1);
   endtask
   initial begin
      int n, ce_hi, first_acc, d0, ale_cnt, bad;
      repeat (3) tick();
      check("rst_held_bus", {ce_n, we_n, re_n, cle, ale, dq_oe}, 6'b111000);
      rst_n = 1'b1;
      tick();
      check("rst_bus", {ce_n, we_n, re_n, cle, ale, dq_oe}, 6'b111000);
      check("rst_dq", dq_o, 8'h00);
      check("rst_status", {req_ready, done, err_timeout, busy}, 4'b1000);
      // reset opcode: single CLE byte
      nb = 0;
      send(8'hFF, 3'd0, 40'h0, 1'b0, 8'h00, 1'b0);
      wait_done(100);
      check("rst_op_latency", last_done - last_acc, 8);
      check("rst_op_nbytes", nb, 1);
      check("rst_op_byte", blog[0], 10'h2FF);
      check("rst_op_we_low", blow[0], 3);
      check("rst_op_err", err_timeout, 0);
      tick();
      check("rst_op_after", {ce_n, req_ready, done, busy}, 4'b1100);
      // page read with R/B_n busy window
      nb = 0;
      rb_total = 7;
      send(8'h00, 3'd5, 40'h0403020100, 1'b1, 8'h30, 1'b1);
      wait_done(600);
      check("pr_nbytes", nb, 7);
      for (int i = 0; i < 7; i++) check($sformatf("pr_byte%0d", i), blog[i], exp_pr[i]);
      bad = 0;
      for (int i = 0; i < 7; i++) if (blow[i] != 3) bad++;
      check("pr_we_low_bad", bad, 0);
      check("pr_byte_pitch", brise[1] - brise[0], 7);
      check("pr_done_after_rise", last_done - brise[6], 213);
      check("pr_done_after_rb", last_done - high_at, 3);
      check("pr_err", err_timeout, 0);
      rb_total = 0; low_at = -1; high_at = -1;
      tick();
      // R/B_n timeout on the short-timeout instance
      req_cmd = 8'h70; req_naddr = 3'd0; req_cmd2_en = 1'b0; req_wait_rb = 1'b1;
      req_valid_t = 1'b1;
      tick();
      req_valid_t = 1'b0;
      check("to_accepted", last_acc_t, cyc - 1);
      repeat (9) tick();
      check("to_wait_wb_bus", {ce_n_t, cle_t, ale_t, dq_oe_t, we_n_t}, 5'b00001);
      n = 0;
      while (!done_t && n < 300) begin tick(); n++; end
      check("to_done_seen", done_t, 1);
      check("to_latency", last_done_t - last_acc_t, 125);
      check("to_err", err_t, 1);
      tick();
      // back-to-back with req_valid held
      nb = 0;
      req_cmd = 8'h90; req_naddr = 3'd1; req_addr = 40'h0; req_cmd2_en = 1'b0; req_wait_rb = 1'b0;
      req_valid = 1'b1;
      tick();
      first_acc = last_acc;
      check("b2b_first_acc", first_acc, cyc - 1);
      req_cmd = 8'hFF; req_naddr = 3'd0;
      n = 0; ce_hi = 0;
      while (last_acc == first_acc && n < 100) begin tick(); n++; if (ce_n) ce_hi++; end
      req_valid = 1'b0;
      check("b2b_first_latency", last_done - first_acc, 15);
      check("b2b_second_acc_gap", last_acc - last_done, 1);
      check("b2b_ce_gap_ok", (ce_hi >= 1 && ce_hi <= 2), 1);
      wait_done(100);
      check("b2b_second_latency", last_done - last_acc, 8);
      check("b2b_nbytes", nb, 3);
      check("b2b_bytes", {blog[0], blog[1], blog[2]}, {10'h290, 10'h100, 10'h2FF});
      tick();
      // asynchronous reset during WE_LOW of the third byte
      nb = 0;
      send(8'h00, 3'd3, 40'h0A0B0C, 1'b0, 8'h00, 1'b0);
      n = 0;
      while (!(nb == 2 && !we_n) && n < 100) begin tick(); n++; end
      check("mid_reached_byte3", {nb == 2, we_n}, 2'b10);
      d0 = last_done;
      rst_n = 1'b0;
      #1;
      check("mid_async_bus", {we_n, ce_n, dq_oe}, 3'b110);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("mid_after_release", {req_ready, busy, done}, 3'b100);
      check("mid_dq", dq_o, 8'h00);
      repeat (20) tick();
      check("mid_no_done", last_done, d0);
      // naddr=7 clamps to five address bytes
      nb = 0;
      send(8'h00, 3'd7, 40'h0504030201, 1'b0, 8'h00, 1'b0);
      wait_done(200);
      ale_cnt = 0;
      for (int i = 0; i < nb; i++) if (blog[i][8]) ale_cnt++;
      check("clamp_ale_count", ale_cnt, 5);
      check("clamp_nbytes", nb, 6);
      check("clamp_latency", last_done - last_acc, 43);
      check("clamp_last_byte", blog[5], 10'h105);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/onfi_cmd_addr_gen.md
Name: onfi_cmd_addr_gen

Overview:
- Drives ONFI command- and address-latch bus cycles toward the NAND device; sits directly downstream of the onfi_top sequencer, which hands it one transaction per request.
- A transaction is one command byte, then 0..5 address bytes (LSB first), then an optional second command byte, then an optional wait for R/B_n.
- Owns CE_n/CLE/ALE/WE_n/DQ timing, counted in sysclk cycles (6 ns period in the system bench).

Parameters:
- T_SETUP, 2: cycles CLE/ALE/DQ are valid before each WE_n falling edge.
- T_WP, 3: WE_n low cycles per byte.
- T_WH, 2: WE_n high/hold cycles after each rising edge.
- T_WB, 17: cycles after the last WE_n rise before R/B_n is sampled.
- RB_TIMEOUT, 65535: max cycles waiting for R/B_n high; width of the timeout counter is $clog2(RB_TIMEOUT+1).

Ports:
- sysclk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  transaction request
- req_ready  out  1  high in IDLE only
- req_cmd  in  8  first command byte
- req_addr  in  40  address bytes, byte0 = [7:0] sent first
- req_naddr  in  3  number of address bytes, 0..5
- req_cmd2_en  in  1  send second command byte
- req_cmd2  in  8  second command byte
- req_wait_rb  in  1  wait for R/B_n after the bus cycles
- done  out  1  one-cycle completion pulse
- err_timeout  out  1  valid with done; R/B_n timeout
- busy  out  1  high whenever not IDLE
- nand_ce_n  out  1  chip enable
- nand_cle  out  1  command latch enable
- nand_ale  out  1  address latch enable
- nand_we_n  out  1  write enable
- nand_re_n  out  1  read enable, held 1 by this block
- nand_dq_o  out  8  DQ output data
- nand_dq_oe  out  1  DQ output enable
- nand_rb_n  in  1  ready/busy_n, asynchronous to sysclk

Behaviour:
- Reset, asynchronous and taking effect immediately, including mid-transaction:
  - State goes to IDLE.
  - nand_ce_n=1, nand_we_n=1, nand_re_n=1, nand_cle=0, nand_ale=0, nand_dq_o=0, nand_dq_oe=0.
  - req_ready=1 after release; done=0, err_timeout=0, busy=0.
- Handshake:
  - Accept on req_valid && req_ready; all req_* fields are latched that cycle.
  - req_ready=0 from the next cycle until the cycle after done.
- req_naddr values 6 and 7 are clamped to 5.
- Byte list: cmd (CLE), then addr[0..naddr-1] (ALE), then cmd2 (CLE) if cmd2_en. Minimum list length is 1.
- States:
  - IDLE -> SETUP on accept.
  - SETUP: ce_n=0, dq_oe=1, dq_o=current byte, cle/ale per byte type, we_n=1. Lasts T_SETUP cycles, then WE_LOW.
  - WE_LOW: we_n=0 for T_WP cycles, then WE_HIGH.
  - WE_HIGH: we_n=1, cle/ale/dq held for T_WH cycles. Next state:
    - next byte exists: SETUP;
    - else req_wait_rb: WAIT_WB;
    - else DONE.
  - WAIT_WB: cle=ale=0, dq_oe=0, ce_n=0. Lasts T_WB cycles, then WAIT_RB.
  - WAIT_RB: leave to DONE when synchronised rb_n=1. Also leave to DONE with err flagged when the counter reaches RB_TIMEOUT.
  - DONE: one cycle. done=1, err_timeout=flag, ce_n=1, cle=ale=0, dq_oe=0. Then IDLE.
- Byte timing: each byte occupies exactly T_SETUP+T_WP+T_WH cycles.
- Transaction latency, accept to done, with registered outputs:
  - Without R/B_n wait: N*(T_SETUP+T_WP+T_WH)+1 cycles, where N = byte count.
  - With R/B_n wait: add T_WB plus the synchronised wait.
- R/B_n handling:
  - nand_rb_n passes through a 2-flop synchroniser (reset value 1); all decisions use the synchronised value.
  - If rb_n is already high when WAIT_RB is entered, the next cycle is DONE.
- Counter widths: the phase counter is sized for max(T_SETUP,T_WP,T_WH,T_WB). All parameters must be >=1; a parameter of 0 is illegal.
- All nand_* outputs are registered, so no glitches appear on we_n.

Decomposition:
- onfi_pkg: state enum, byte-type encoding (CMD/ADDR), opcode constants RESET=8'hFF, READ1=8'h00, READ2=8'h30, READ_STATUS=8'h70, READ_ID=8'h90, PROG1=8'h80, PROG2=8'h10, ERASE1=8'h60, ERASE2=8'hD0.
- Sub-module onfi_sync2: generic 2-flop synchroniser with reset value parameter, used for nand_rb_n.

Test Plan:
- Reset op: cmd=8'hFF, naddr=0, cmd2_en=0, wait_rb=0 -> one CLE byte with dq_o=FF; WE_n low exactly 3 cycles; done 8 cycles after accept; ce_n=1 after done.
- Page read: cmd=00, naddr=5, addr=40'h0403020100, cmd2=30, wait_rb=1; model pulls rb_n low 10 cycles after the last WE_n rise and releases it 200 cycles later -> DQ sequence 00,00,01,02,03,04,30 with CLE,ALE×5,CLE; done after rb_n high plus 2-3 sync cycles; err_timeout=0.
- Timeout: RB_TIMEOUT=100, rb_n held low -> done with err_timeout=1 exactly 100 cycles after WAIT_RB entry.
- Back-to-back: req_valid held high with two requests -> second accepted the cycle after done; no overlap of ce_n low windows across the boundary other than a single ce_n=1 cycle.
- Reset mid-transaction: assert rst_n=0 during the WE_LOW of byte 3 -> we_n=1, ce_n=1, dq_oe=0 immediately (asynchronously); after release IDLE with req_ready=1 and no done.
- naddr=7 -> exactly 5 ALE bytes issued.
